// File: rtl/pacman_move_scheduler.sv
// Pac-Man move scheduler: buffers one turn, divides clk into move ticks, issues steps over req/ack.
// Optional MOVE_BTN_SYNC_EN adds a 2-flop synchronizer on each button.
module pacman_move_scheduler #(
    parameter int TICK_DIV = 1000000,
    parameter int BUF_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic [3:0] legal_moves,
    input  logic       step_ack,
    output logic       step_req,
    output logic [3:0] step_dir,
    output logic [3:0] curr_direction,
    output logic [3:0] pending_dir,
    output logic       stalled
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0] HOLD_INIT = 4'(BUF_HOLD);
    localparam logic [3:0] DIR_L = 4'b1000;
    localparam logic [3:0] DIR_R = 4'b0100;
    localparam logic [3:0] DIR_U = 4'b0010;
    localparam logic [3:0] DIR_D = 4'b0001;

    typedef enum logic [1:0] {
        WAIT_TICK = 2'd0,
        EVAL      = 2'd1,
        REQ       = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hold_q, hold_d;
    logic [3:0]    curr_q, curr_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    sdir_q, sdir_d;
    logic          req_q, req_d;
    logic          stall_q, stall_d;

    logic [3:0]    btn_raw;
    logic [3:0]    btn;
    logic [3:0]    press;
    logic [3:0]    heading;

    assign btn_raw = {btn_l, btn_r, btn_u, btn_d};

`ifdef MOVE_BTN_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn = sync2_q;
`else
    assign btn = btn_raw;
`endif

    // Fixed priority L > R > U > D when several buttons are held.
    always_comb begin
        press = '0;
        if (btn[3]) begin
            press = DIR_L;
        end else if (btn[2]) begin
            press = DIR_R;
        end else if (btn[1]) begin
            press = DIR_U;
        end else if (btn[0]) begin
            press = DIR_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_TICK;
            cnt_q   <= '0;
            hold_q  <= '0;
            curr_q  <= DIR_L;
            pend_q  <= '0;
            sdir_q  <= '0;
            req_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            curr_q  <= curr_d;
            pend_q  <= pend_d;
            sdir_q  <= sdir_d;
            req_q   <= req_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        curr_d  = curr_q;
        pend_d  = pend_q;
        sdir_d  = sdir_q;
        req_d   = req_q;
        stall_d = stall_q;
        heading = curr_q;

        unique case (state_q)
            WAIT_TICK: begin
                if (enable) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EVAL: begin
                if ((pend_q & legal_moves) != 4'b0) begin
                    heading = pend_q;
                    pend_d  = '0;
                end else if (pend_q != 4'b0) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= 4'd1) begin
                        pend_d = '0;
                    end
                end
                curr_d = heading;
                if ((heading & legal_moves) != 4'b0) begin
                    sdir_d  = heading;
                    req_d   = 1'b1;
                    stall_d = 1'b0;
                    state_d = REQ;
                end else begin
                    stall_d = 1'b1;
                    state_d = WAIT_TICK;
                end
            end
            REQ: begin
                if (step_ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT_TICK;
                end
            end
            default: begin
                state_d = WAIT_TICK;
            end
        endcase

        // A fresh press overrides whatever EVAL decided for the buffer.
        if (press != 4'b0) begin
            pend_d = press;
            hold_d = HOLD_INIT;
        end
    end

    assign step_req       = req_q;
    assign step_dir       = sdir_q;
    assign curr_direction = curr_q;
    assign pending_dir    = pend_q;
    assign stalled        = stall_q;

endmodule

// File: tb/tb_pacman_move_scheduler.sv
// Bench for pacman_move_scheduler: directed scenarios plus random traffic
// checked every cycle against an index-based behavioural model.
module tb_pacman_move_scheduler;

    localparam int TD = 8;
    localparam int BH = 2;
`ifdef MOVE_BTN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic       btn_u = 1'b0;
    logic       btn_d = 1'b0;
    logic [3:0] legal_moves = 4'b0;
    logic       step_ack = 1'b0;
    logic       step_req;
    logic [3:0] step_dir;
    logic [3:0] curr_direction;
    logic [3:0] pending_dir;
    logic       stalled;

    int total = 0;
    int bad = 0;

    pacman_move_scheduler #(.TICK_DIV(TD), .BUF_HOLD(BH)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .btn_l(btn_l),
        .btn_r(btn_r),
        .btn_u(btn_u),
        .btn_d(btn_d),
        .legal_moves(legal_moves),
        .step_ack(step_ack),
        .step_req(step_req),
        .step_dir(step_dir),
        .curr_direction(curr_direction),
        .pending_dir(pending_dir),
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: directions as indices 0..3 = L,R,U,D; -1 means none.
    int  m_head, m_pend, m_life, m_wait, m_sdir;
    bit  m_tick, m_busy, m_stall;
    logic [3:0] m_s1, m_s2;

    function automatic logic [3:0] oh(input int idx);
        return (idx < 0) ? 4'b0 : (4'b1000 >> idx);
    endfunction

    function automatic bit can_go(input logic [3:0] lm, input int idx);
        return (idx >= 0) && ((lm & oh(idx)) != 4'b0);
    endfunction

    task automatic model_step();
        logic [3:0] b;
        int p;
        if (rst) begin
            m_head = 0; m_pend = -1; m_life = 0; m_wait = 0;
            m_sdir = -1; m_tick = 0; m_busy = 0; m_stall = 0;
            m_s1 = 0; m_s2 = 0;
            return;
        end
`ifdef MOVE_BTN_SYNC_EN
        b = m_s2;
        m_s2 = m_s1;
        m_s1 = {btn_l, btn_r, btn_u, btn_d};
`else
        b = {btn_l, btn_r, btn_u, btn_d};
`endif
        p = -1;
        for (int i = 3; i >= 0; i--) begin
            if (b[i] && p < 0) p = 3 - i;
        end
        if (m_busy) begin
            if (step_ack) m_busy = 0;
        end else if (m_tick) begin
            m_tick = 0;
            if (can_go(legal_moves, m_pend)) begin
                m_head = m_pend;
                m_pend = -1;
            end else if (m_pend >= 0) begin
                m_life--;
                if (m_life == 0) m_pend = -1;
            end
            if (can_go(legal_moves, m_head)) begin
                m_sdir = m_head; m_busy = 1; m_stall = 0;
            end else begin
                m_stall = 1;
            end
        end else if (enable) begin
            if (m_wait == TD - 1) begin
                m_wait = 0; m_tick = 1;
            end else begin
                m_wait++;
            end
        end
        if (p >= 0) begin
            m_pend = p;
            m_life = BH;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] b,
                        input logic [3:0] lm, input bit a);
        @(negedge clk);
        rst = r;
        enable = e;
        {btn_l, btn_r, btn_u, btn_d} = b;
        legal_moves = lm;
        step_ack = a;
        @(posedge clk);
        model_step();
        #1;
        chk("req", int'(step_req), int'(m_busy));
        chk("sdir", int'(step_dir), int'(oh(m_sdir)));
        chk("curr", int'(curr_direction), int'(oh(m_head)));
        chk("pend", int'(pending_dir), int'(oh(m_pend)));
        chk("stall", int'(stalled), int'(m_stall));
    endtask

    task automatic first_req(output int n);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step(0, 1, 4'b0, 4'b1000, 0);
            if (step_req) n = i;
        end
    endtask

    int n;
    int cyc;
    logic [3:0] rb;

    initial begin
        // Reset state
        step(1, 0, 4'b0, 4'b1000, 0);
        chk("rst_curr", int'(curr_direction), 8);
        chk("rst_req", int'(step_req), 0);
        chk("rst_pend", int'(pending_dir), 0);
        chk("rst_sdir", int'(step_dir), 0);

        // First tick: request 9 edges after reset release
        first_req(n);
        chk("first_req_cyc", n, 9);
        chk("first_req_dir", int'(step_dir), 8);
        step(0, 1, 4'b0, 4'b1000, 1);
        chk("ack_drop", int'(step_req), 0);
        first_req(n);
        chk("next_req_cyc", n, 9);
        step(0, 1, 4'b0, 4'b1000, 1);

        // L and R together: L wins
        step(0, 1, 4'b1100, 4'b1000, 0);
        for (int i = 1; i < LAT; i++) step(0, 1, 4'b0, 4'b1000, 0);
        chk("prio_lr", int'(pending_dir), 8);

        // Illegal D turn expires after BH evaluations
        step(1, 0, 4'b0, 4'b1000, 0);
        step(0, 1, 4'b0001, 4'b1000, 1);
        for (int i = 2; i <= 12; i++) step(0, 1, 4'b0, 4'b1000, 1);
        chk("hold_kept", int'(pending_dir), 1);
        for (int i = 13; i <= 20; i++) step(0, 1, 4'b0, 4'b1000, 1);
        chk("hold_gone", int'(pending_dir), 0);
        chk("hold_curr", int'(curr_direction), 8);

        // Blocked heading stalls, then recovers
        for (int i = 0; i < 10; i++) step(0, 1, 4'b0, 4'b0001, 0);
        chk("stall_set", int'(stalled), 1);
        chk("stall_noreq", int'(step_req), 0);
        for (int i = 0; i < 10; i++) step(0, 1, 4'b0, 4'b1001, 0);
        chk("stall_req", int'(step_req), 1);
        chk("stall_dir", int'(step_dir), 8);
        chk("stall_clr", int'(stalled), 0);

        // Withheld ack, then reset mid-handshake
        for (int i = 0; i < 20; i++) step(0, 0, 4'b0, 4'b1001, 0);
        chk("hold_req", int'(step_req), 1);
        step(1, 1, 4'b0, 4'b1000, 0);
        chk("rst_mid_req", int'(step_req), 0);
        chk("rst_mid_curr", int'(curr_direction), 8);
        first_req(n);
        chk("rst_restart", n, 9);

        // Random traffic
        for (cyc = 0; cyc < 4000; cyc++) begin
            rb = 4'b0;
            for (int k = 0; k < 4; k++) rb[k] = ($urandom_range(0, 39) == 0);
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) != 0),
                 rb,
                 4'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
